// File: rtl/sram_like_data_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_data_ram_if
//  Description : Core-side sram-like data port bundle (request, handshake,
//                response and merged-write bench hook).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_like_data_ram_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_write;

    // The core issues requests and consumes responses.
    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok, data_write
    );

    // The memory model accepts requests and produces responses.
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok, data_write
    );
endinterface
`default_nettype wire

// File: rtl/sram_like_data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_data_ram
//  Description : Behavioural data memory on the sram-like data port. Accepts
//                pipelined requests via addr_ok, applies byte-lane writes at
//                acceptance and returns in-order responses via data_ok after
//                LATENCY cycles. Optional LFSR back-pressure on addr_ok.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_like_data_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4,
    parameter bit STALL_EN   = 1'b0
) (
    input wire                 clk,
    input wire                 rst,
    sram_like_data_ram_if.slave bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_cd_w  = 4;
    localparam int c_words = 2 ** ADDR_WIDTH;

    localparam logic [c_cd_w-1:0]  c_cd_init = c_cd_w'(LATENCY - 1);
    localparam logic [c_cd_w-1:0]  c_cd_one  = c_cd_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [15:0]        c_seed    = 16'hACE1;

    // Word storage; intentionally not cleared by reset.
    logic [31:0] ram [0:c_words-1];

    // Response queue entries.
    logic [31:0]        r_fifo_rdata [DEPTH];
    logic               r_fifo_wr    [DEPTH];
    logic [c_cd_w-1:0]  r_fifo_cd    [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic [15:0]        r_lfsr;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_stall;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_lfsr_fb;
    logic                  w_unused;

    // Address bits above the word index alias onto the same storage.
    assign w_unused  = &{1'b0, bus.data_addr[31:ADDR_WIDTH+2]};

    assign w_idx     = bus.data_addr[ADDR_WIDTH+1:2];
    assign w_old     = ram[w_idx];
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_stall   = STALL_EN && r_lfsr[0] && r_lfsr[3];

    // A pop in the same cycle is deliberately ignored, so a full queue
    // refuses for one extra cycle.
    assign w_addr_ok = (r_count < c_depth) && !w_stall;
    assign w_accept  = bus.data_req && w_addr_ok;
    assign w_pop     = (r_count != '0) && (r_fifo_cd[r_rptr] == '0);

    assign bus.data_addr_ok = w_addr_ok;
    assign bus.data_data_ok = w_pop;
    assign bus.data_rdata   = (w_pop && !r_fifo_wr[r_rptr]) ? r_fifo_rdata[r_rptr] : 32'h0;
    assign bus.data_write   = w_merged;

    // Byte-lane enables from size and low address bits; size 3 acts as word.
    always_comb begin
        w_be = 4'b1111;
        case (bus.data_size)
            2'd0:    w_be = 4'b0001 << bus.data_addr[1:0];
            2'd1:    w_be = 4'b0011 << bus.data_addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    // Merge enabled lanes of the write data over the currently stored word.
    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_merged[8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
        end
    end

    // Writes land at the accepting edge so later reads see them directly.
    always_ff @(posedge clk) begin
        if (w_accept && bus.data_wr && !rst) begin
            ram[w_idx] <= w_merged;
        end
    end

    // Free-running back-pressure LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_seed;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Response queue: push on accept, age all countdowns, pop the ripe head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_fifo_cd[i] != '0) begin
                    r_fifo_cd[i] <= r_fifo_cd[i] - c_cd_one;
                end
            end
            if (w_accept) begin
                r_fifo_cd[r_wptr]    <= c_cd_init;
                r_fifo_rdata[r_wptr] <= w_old;
                r_fifo_wr[r_wptr]    <= bus.data_wr;
                r_wptr               <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_like_data_ram.md
# sram_like_data_ram

Behavioural data memory on the core's sram-like data port, the downstream consumer of the `data_*` bus in the simulation bench. It accepts pipelined requests through the `addr_ok` handshake and applies byte-lane writes. It returns in-order responses through `data_ok` after a configurable latency. Optional pseudo-random back-pressure exercises the core's stall paths.

## Interface
- `ADDR_WIDTH`, 16: word-index bits; storage is `ram[0:2**ADDR_WIDTH-1]`, 32-bit words.
- `LATENCY`, 2: cycles from acceptance to `data_ok`; legal range 1..8.
- `DEPTH`, 4: maximum outstanding requests (power of two, ≥2).
- `STALL_EN`, 0: 1 enables LFSR back-pressure on `addr_ok`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_req`  in  1  request valid.
- `data_wr`  in  1  1 = write, 0 = read.
- `data_size`  in  2  0 byte, 1 half, 2 word; 3 treated as word.
- `data_addr`  in  32  byte address.
- `data_wdata`  in  32  write data, already lane-aligned by the core.
- `data_rdata`  out  32  read word, valid while `data_ok`.
- `data_addr_ok`  out  1  request accepted this cycle when high with `data_req`.
- `data_data_ok`  out  1  one response retired this cycle.
- `data_write`  out  32  combinational merged word (old word with enabled lanes replaced); bench hook, meaningful when a write is accepted.

## Operation
- Word index = `data_addr[ADDR_WIDTH+1:2]`; higher address bits ignored (aliasing).
- Byte enables: size 0 → `4'b0001 << addr[1:0]`; size 1 → `4'b0011 << addr[1:0]`, truncated to 4 bits; size 2/3 → `4'b1111`.
- Accept = `data_req && data_addr_ok`. On the accepting edge:
  - write: `ram[idx] <= data_write`.
  - read: the word is captured into the response entry at that same edge.
  - Program-order read-after-write is therefore correct without forwarding.
- Response queue: a DEPTH-entry FIFO. Each entry holds `{rdata, is_write, countdown}`; countdown loads `LATENCY-1`. Countdowns of all entries decrement each cycle, saturating at 0.
- `data_data_ok` = FIFO non-empty and head countdown == 0. The pop happens on that edge. At most one response per cycle, strictly in acceptance order.
- `data_rdata` = head rdata when `data_ok`, else 0. Write responses return `data_rdata` = 0.
- `data_addr_ok` = `count < DEPTH && !stall`. A same-cycle pop is not considered, so a full queue blocks for one cycle.
- Simultaneous push and pop: count unchanged; the new entry goes to the tail.
- `stall` = `STALL_EN && lfsr[0] && lfsr[3]` (≈25% duty). `lfsr` is a 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1, advancing every cycle.
- `addr_ok` does not depend on `data_req`. The core may change or drop the request while `addr_ok` is low.

## Timing
- Reset values: `data_addr_ok` 1 (0 if the first LFSR state stalls), `data_data_ok` 0, `data_rdata` 0, count 0, FIFO pointers 0, lfsr 16'hACE1.
- `ram` is not cleared by reset; the bench initialises it hierarchically.
- Request accepted at edge k, queue otherwise idle: `data_ok` is high in the cycle following edge k+LATENCY-1. With LATENCY=1, `data_ok` is high in the cycle right after acceptance.
- Back-to-back accepts each cycle produce back-to-back `data_ok`, offset by LATENCY. Sustained throughput is 1 per cycle when DEPTH ≥ LATENCY+1.
- Reset asserted mid-operation discards all outstanding responses. No `data_ok` is issued for them. Writes already accepted stay in `ram`.

## Test plan
- Word write 0xDEADBEEF to 0x100, then read 0x100 (LATENCY=2) → write `data_ok` at acceptance+2, read `data_ok` at its acceptance+2 with rdata 0xDEADBEEF.
- Byte write wdata 0x00AB0000, size 0, addr 0x102, over word 0x11223344 → `data_write` = 0x11AB3344, and a subsequent read returns it.
- Half write wdata 0xCAFE0000, size 1, addr 0x202, over 0 → stored 0xCAFE0000. Size 3 is treated as a full-word write.
- DEPTH=4, LATENCY=8, `data_req` held high for 6 cycles → exactly 4 accepts, then `addr_ok` low until the first `data_ok`. Four in-order responses follow.
- LATENCY=1, continuous reads of addresses 0,4,8,12 → `data_ok` on 4 consecutive cycles with the matching words, and `addr_ok` never drops.
- Three reads outstanding, `rst` pulsed for 1 cycle → no `data_ok` afterwards, `addr_ok` high next cycle. A new read completes normally.
- STALL_EN=1, 200 random requests → every accepted read returns the last written value, and `addr_ok` low-cycle count is nonzero.
